// File: rtl/divider_if.sv
// rtl/divider_if.sv - begin/end pulse handshake and operand/result bundle for the divider
interface divider_if #(
    parameter int WIDTH = 32
);
    logic             div_begin;
    logic             div_signed;
    logic [WIDTH-1:0] div_op1;
    logic [WIDTH-1:0] div_op2;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             div_end;

    modport master (
        output div_begin, div_signed, div_op1, div_op2,
        input  quotient, remainder, div_by_zero, busy, div_end
    );

    modport slave (
        input  div_begin, div_signed, div_op1, div_op2,
        output quotient, remainder, div_by_zero, busy, div_end
    );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - iterative restoring divider, one quotient bit per clock, signed/unsigned
module divider #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     resetn,
    divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CALC = 3'b010,
        SIGN = 3'b100
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;      // dividend magnitude, shifts out as quotient bits shift in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] op1_raw;
    logic             q_sign, r_sign, dz;

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] diff;
    logic             borrow_raw, borrow;
    logic             iter_done;

    // rem[WIDTH-1] is the carry-out of the shift; when set the shifted value
    // exceeds any divisor, so the subtract can never borrow.
    always_comb begin
        shl                = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        {borrow_raw, diff} = {1'b0, shl} - {1'b0, dvs};
        borrow             = borrow_raw & ~rem[WIDTH-1];
        iter_done          = (cnt == CW'(WIDTH));
    end

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = bus.div_begin ? CALC : IDLE;
            CALC:    state_n = iter_done ? SIGN : CALC;
            SIGN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt             <= '0;
            dvd             <= '0;
            dvs             <= '0;
            rem             <= '0;
            op1_raw         <= '0;
            q_sign          <= 1'b0;
            r_sign          <= 1'b0;
            dz              <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
            bus.busy        <= 1'b0;
            bus.div_end     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.div_end <= 1'b0;
                    if (bus.div_begin) begin
                        dvd      <= (bus.div_signed && bus.div_op1[WIDTH-1]) ? -bus.div_op1 : bus.div_op1;
                        dvs      <= (bus.div_signed && bus.div_op2[WIDTH-1]) ? -bus.div_op2 : bus.div_op2;
                        q_sign   <= bus.div_signed & (bus.div_op1[WIDTH-1] ^ bus.div_op2[WIDTH-1]);
                        r_sign   <= bus.div_signed & bus.div_op1[WIDTH-1];
                        dz       <= (bus.div_op2 == '0);
                        op1_raw  <= bus.div_op1;
                        rem      <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                CALC: begin
                    if (!iter_done) begin
                        rem <= borrow ? shl : diff;
                        dvd <= {dvd[WIDTH-2:0], ~borrow};
                        cnt <= cnt + 1'b1;
                    end
                end
                SIGN: begin
                    if (dz) begin
                        bus.quotient    <= '1;
                        bus.remainder   <= op1_raw;
                        bus.div_by_zero <= 1'b1;
                    end else begin
                        bus.quotient    <= q_sign ? -dvd : dvd;
                        bus.remainder   <= r_sign ? -rem : rem;
                        bus.div_by_zero <= 1'b0;
                    end
                    bus.div_end <= 1'b1;
                    bus.busy    <= 1'b0;
                end
                default: begin
                    bus.div_end <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
